// File: rtl/seq_muldiv_pkg.sv
// Shared definitions for the sequential multiply/divide unit:
// op encodings, FSM states and a magnitude helper.
package muldiv_pkg;

    localparam logic [1:0] MULT  = 2'b00;
    localparam logic [1:0] MULTU = 2'b01;
    localparam logic [1:0] DIV   = 2'b10;
    localparam logic [1:0] DIVU  = 2'b11;

    localparam int MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    // Callers zero-extend into MAX_W and truncate back; the low bits
    // of a two's-complement negation do not depend on the extension.
    function automatic logic [MAX_W-1:0] mag(
        input logic [MAX_W-1:0] v,
        input logic             neg
    );
        return neg ? (~v + MAX_W'(1)) : v;
    endfunction

endpackage

// File: rtl/seq_muldiv_if.sv
// Request/result bundle between the datapath control and the
// mult/div engine, including the mthi/mtlo direct-write path.
interface seq_muldiv_if #(
    parameter int WIDTH = 32
);

    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] hi_wdata;
    logic [WIDTH-1:0] lo_wdata;
    logic             busy;
    logic             ready;
    logic             div_by_zero;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, a, b,
        output hi_we, lo_we, hi_wdata, lo_wdata,
        input  busy, ready, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, a, b,
        input  hi_we, lo_we, hi_wdata, lo_wdata,
        output busy, ready, div_by_zero, hi, lo
    );

endinterface

// File: rtl/seq_muldiv.sv
// One-bit-per-cycle multiply/divide engine with HI/LO registers.
// Operates on magnitudes and fixes signs in a single FIX cycle.
module seq_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic         clk,
    input  logic         reset,
    seq_muldiv_if.slave  bus
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int W2 = 2 * WIDTH;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    state_t state;
    state_t state_nx;

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] dvs;
    logic [WIDTH-1:0] mq;
    logic [CW-1:0]    cnt;
    logic             is_div_q;
    logic             sign_a;
    logic             sign_b;
    logic             b_zero;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             dbz_q;

    logic             busy;
    logic             accept;
    logic             is_div;
    logic             is_signed;
    logic             neg_a;
    logic             neg_b;
    logic             neg_q;
    logic [WIDTH:0]   mul_sum;
    logic             div_ok;
    logic [WIDTH-1:0] div_diff;
    logic [W2-1:0]    prod;
    logic [W2-1:0]    prod_fix;
    logic [WIDTH-1:0] quot_fix;
    logic [WIDTH-1:0] rem_fix;

    assign busy   = (state == CALC) || (state == FIX);
    assign accept = bus.start && !busy;

    assign is_div    = (bus.op == DIV) || (bus.op == DIVU);
    assign is_signed = (bus.op == MULT) || (bus.op == DIV);
    assign neg_a     = is_signed && bus.a[WIDTH-1];
    assign neg_b     = is_signed && bus.b[WIDTH-1];
    assign neg_q     = sign_a ^ sign_b;

    assign mul_sum = (WIDTH+1)'(acc)
                   + (WIDTH+1)'(mq[0] ? dvs : '0);

    // The running remainder may exceed the divisor only when it is zero,
    // so compare at full width and subtract modulo 2^WIDTH.
    assign div_ok   = {acc, mq[WIDTH-1]} >= {1'b0, dvs};
    assign div_diff = {acc[WIDTH-2:0], mq[WIDTH-1]} - dvs;

    assign prod     = {acc, mq};
    assign prod_fix = neg_q ? (~prod + W2'(1)) : prod;
    assign quot_fix = b_zero ? '1
                    : WIDTH'(mag(MAX_W'(mq), neg_q));
    assign rem_fix  = WIDTH'(mag(MAX_W'(acc), sign_a));

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (accept) state_nx = CALC;
            CALC:    if (cnt == LAST) state_nx = FIX;
            FIX:     state_nx = DONE;
            DONE:    state_nx = accept ? CALC : IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            is_div_q <= is_div;
            sign_a   <= neg_a;
            sign_b   <= neg_b;
            b_zero   <= (bus.b == '0);
            acc      <= '0;
            dvs      <= WIDTH'(mag(MAX_W'(bus.b), neg_b));
            mq       <= WIDTH'(mag(MAX_W'(bus.a), neg_a));
            cnt      <= '0;
        end else if (state == CALC) begin
            cnt <= cnt + CW'(1);
            if (is_div_q) begin
                acc <= div_ok ? div_diff
                              : {acc[WIDTH-2:0], mq[WIDTH-1]};
                mq  <= {mq[WIDTH-2:0], div_ok};
            end else begin
                acc <= mul_sum[WIDTH:1];
                mq  <= {mul_sum[0], mq[WIDTH-1:1]};
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q  <= '0;
            lo_q  <= '0;
            dbz_q <= 1'b0;
        end else if (state == FIX) begin
            if (is_div_q) begin
                hi_q <= rem_fix;
                lo_q <= quot_fix;
            end else begin
                {hi_q, lo_q} <= prod_fix;
            end
            dbz_q <= is_div_q && b_zero;
        end else begin
            if (accept) dbz_q <= 1'b0;
            if (!busy && bus.hi_we) hi_q <= bus.hi_wdata;
            if (!busy && bus.lo_we) lo_q <= bus.lo_wdata;
        end
    end

    assign bus.busy        = busy;
    assign bus.ready       = (state == DONE);
    assign bus.div_by_zero = dbz_q;
    assign bus.hi          = hi_q;
    assign bus.lo          = lo_q;

endmodule

// File: tb/tb_seq_muldiv.sv
// Directed bench for seq_muldiv at WIDTH=32 and WIDTH=8:
// latency, HI/LO results, div-by-zero, ignored requests, reset abort.
module tb_seq_muldiv;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   failures = 0;
    logic d1;

    always #5 clk = ~clk;

    seq_muldiv_if #(.WIDTH(32)) bus32();
    seq_muldiv_if #(.WIDTH(8))  bus8();

    seq_muldiv #(.WIDTH(32)) dut32 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus32.slave)
    );

    seq_muldiv #(.WIDTH(8)) dut8 (
        .clk   (clk),
        .reset (reset),
        .bus   (bus8.slave)
    );

    task automatic check(input string tag,
                         input logic [63:0] got,
                         input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Issue one op on the 32-bit unit; returns at the negedge of the
    // ready cycle. With poke set, a competing start and an mthi are
    // driven in cycle 5 and must both be ignored.
    task automatic op32(input logic [1:0]  o,
                        input logic [31:0] x,
                        input logic [31:0] y,
                        input bit          poke,
                        output logic       dbz1);
        int k;
        int bc;
        bit seen;
        @(negedge clk);
        bus32.start = 1'b1;
        bus32.op = o;
        bus32.a = x;
        bus32.b = y;
        @(negedge clk);
        bus32.start = 1'b0;
        k = 1;
        bc = 0;
        seen = 0;
        dbz1 = 1'bx;
        while (!seen && k < 100) begin
            if (k == 1) dbz1 = bus32.div_by_zero;
            if (bus32.busy) bc++;
            if (bus32.ready) begin
                seen = 1;
            end else begin
                if (poke && k == 5) begin
                    bus32.start = 1'b1;
                    bus32.op = MULTU;
                    bus32.a = 32'd9;
                    bus32.b = 32'd9;
                    bus32.hi_we = 1'b1;
                    bus32.hi_wdata = 32'hDEAD_BEEF;
                end else if (poke && k == 6) begin
                    bus32.start = 1'b0;
                    bus32.hi_we = 1'b0;
                end
                @(negedge clk);
                k++;
            end
        end
        check("lat32", k, 34);
        check("busy32", bc, 33);
    endtask

    task automatic op8(input logic [1:0] o,
                       input logic [7:0] x,
                       input logic [7:0] y);
        int k;
        int bc;
        bit seen;
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.op = o;
        bus8.a = x;
        bus8.b = y;
        @(negedge clk);
        bus8.start = 1'b0;
        k = 1;
        bc = 0;
        seen = 0;
        while (!seen && k < 40) begin
            if (bus8.busy) bc++;
            if (bus8.ready) begin
                seen = 1;
            end else begin
                @(negedge clk);
                k++;
            end
        end
        check("lat8", k, 10);
        check("busy8", bc, 9);
    endtask

    initial begin
        bus32.start = 0;  bus32.op = '0;
        bus32.a = '0;     bus32.b = '0;
        bus32.hi_we = 0;  bus32.lo_we = 0;
        bus32.hi_wdata = '0;
        bus32.lo_wdata = '0;
        bus8.start = 0;   bus8.op = '0;
        bus8.a = '0;      bus8.b = '0;
        bus8.hi_we = 0;   bus8.lo_we = 0;
        bus8.hi_wdata = '0;
        bus8.lo_wdata = '0;

        repeat (3) @(negedge clk);
        check("rst_busy", bus32.busy, 0);
        check("rst_ready", bus32.ready, 0);
        check("rst_dbz", bus32.div_by_zero, 0);
        check("rst_hi", bus32.hi, 0);
        check("rst_lo", bus32.lo, 0);
        check("rst8_hilo", {bus8.hi, bus8.lo}, 0);
        reset = 1'b0;

        op32(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, d1);
        check("multu_hi", bus32.hi, 32'hFFFF_FFFE);
        check("multu_lo", bus32.lo, 32'h0000_0001);
        check("multu_dbz", bus32.div_by_zero, 0);
        @(negedge clk);
        check("multu_pulse", bus32.ready, 0);

        op32(MULT, -32'sd3, 32'd7, 0, d1);
        check("mult_hi", bus32.hi, 32'hFFFF_FFFF);
        check("mult_lo", bus32.lo, 32'hFFFF_FFEB);

        op32(DIV, -32'sd7, 32'd2, 0, d1);
        check("div_lo", bus32.lo, 32'hFFFF_FFFD);
        check("div_hi", bus32.hi, 32'hFFFF_FFFF);

        op32(DIVU, 32'd100, 32'd7, 0, d1);
        check("divu_lo", bus32.lo, 14);
        check("divu_hi", bus32.hi, 2);

        op32(DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0, d1);
        check("ovf_lo", bus32.lo, 32'h8000_0000);
        check("ovf_hi", bus32.hi, 0);

        op32(DIVU, 32'd5, 32'd0, 0, d1);
        check("dz_lo", bus32.lo, 32'hFFFF_FFFF);
        check("dz_hi", bus32.hi, 5);
        check("dz_flag", bus32.div_by_zero, 1);
        repeat (2) @(negedge clk);
        check("dz_held", bus32.div_by_zero, 1);
        check("dz_noready", bus32.ready, 0);

        op32(MULTU, 32'd6, 32'd7, 1, d1);
        check("dz_clear", d1, 0);
        check("ign_lo", bus32.lo, 42);
        check("ign_hi", bus32.hi, 0);
        check("ign_dbz", bus32.div_by_zero, 0);

        @(negedge clk);
        bus32.lo_we = 1'b1;
        bus32.lo_wdata = 32'h1234;
        @(negedge clk);
        bus32.lo_we = 1'b0;
        check("mtlo_lo", bus32.lo, 32'h1234);
        check("mtlo_hi", bus32.hi, 0);

        @(negedge clk);
        bus32.start = 1'b1;
        bus32.op = DIVU;
        bus32.a = 32'd100;
        bus32.b = 32'd7;
        @(negedge clk);
        bus32.start = 1'b0;
        repeat (9) @(negedge clk);
        check("pre_rst_busy", bus32.busy, 1);
        reset = 1'b1;
        @(negedge clk);
        check("abort_busy", bus32.busy, 0);
        check("abort_ready", bus32.ready, 0);
        check("abort_hilo", {bus32.hi, bus32.lo}, 0);
        reset = 1'b0;
        op32(DIVU, 32'd100, 32'd7, 0, d1);
        check("restart_lo", bus32.lo, 14);
        check("restart_hi", bus32.hi, 2);

        op8(MULTU, 8'hFF, 8'h02);
        check("w8_mul_hi", bus8.hi, 8'h01);
        check("w8_mul_lo", bus8.lo, 8'hFE);

        op8(DIV, 8'h80, 8'hFF);
        check("w8_ovf_lo", bus8.lo, 8'h80);
        check("w8_ovf_hi", bus8.hi, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_muldiv.md
# seq_muldiv

Parametrised sequential multiply/divide unit with architectural HI/LO registers, serving as the integer mult/div engine of the multi-cycle MIPS datapath. It accepts one operation per start pulse: signed or unsigned multiply, or signed or unsigned divide. It iterates one bit per cycle and delivers a 2×WIDTH result into HI/LO with a one-cycle ready pulse. It also supports direct HI/LO writes for mthi/mtlo.

## Interface
- WIDTH, 32, operand width; HI and LO are each WIDTH bits; legal range 4..64.
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  synchronous, active-high.
- start  in  1  request; accepted only when busy=0.
- op  in  2  operation, sampled with start: MULT=00, MULTU=01, DIV=10, DIVU=11.
- a  in  WIDTH  operand A / dividend, sampled with start.
- b  in  WIDTH  operand B / divisor, sampled with start.
- hi_we  in  1  direct write of hi_wdata into HI (mthi).
- lo_we  in  1  direct write of lo_wdata into LO (mtlo).
- hi_wdata, lo_wdata  in  WIDTH  direct-write data.
- busy  out  1  operation in progress; reset 0.
- ready  out  1  single-cycle completion pulse; reset 0.
- div_by_zero  out  1  last accepted op was a divide with b=0; valid from ready, held until next accepted start; reset 0.
- hi, lo  out  WIDTH  architectural HI/LO; reset 0.

## Operation
- States: IDLE, CALC, FIX, DONE.
  - IDLE: start=1 latches op, the operands and their signs. It loads |a| and |b| (two's-complement magnitude for MULT/DIV, raw for MULTU/DIVU), clears the iteration counter, and moves to CALC.
  - CALC: runs exactly WIDTH iterations.
    - Multiply: shift-add, one multiplier bit per cycle, into a 2×WIDTH accumulator.
    - Divide: restoring shift-subtract, one quotient bit per cycle.
  - FIX: applies sign correction, then writes HI/LO.
  - DONE: asserts ready for one cycle, then returns to IDLE.
- Multiply results: {hi,lo} = 2×WIDTH product. Signed result = negation of the magnitude product when sign(a)≠sign(b).
- Divide results:
  - lo = quotient, hi = remainder.
  - Signed: quotient is negated when sign(a)≠sign(b). Remainder takes the sign of the dividend, so the quotient truncates toward zero.
  - Signed overflow (most-negative / −1): lo = most-negative value, hi = 0. This falls out of the magnitude arithmetic with no special case.
  - b=0 (either divide op): lo = all ones, hi = a unmodified, div_by_zero=1. Full latency is preserved.
- Direct writes:
  - hi_we/lo_we take effect at the next edge only when busy=0; they are ignored while busy.
  - A direct write in the same cycle as an accepted start is performed, and the op result later overwrites it.
- start while busy=1 is ignored and not queued.
- The op does not alter HI/LO until the FIX edge; intermediate values are held in internal registers only.

## Timing
- Start accepted in cycle 0 (start=1, busy=0).
- busy is high in cycles 1..WIDTH+1.
- hi/lo take the new values at the edge ending cycle WIDTH+1.
- ready=1 only in cycle WIDTH+2, with busy=0 in that cycle. A new start may be accepted in cycle WIDTH+2.
- Latency is fixed at WIDTH+2 cycles, independent of op and operand values.
- Reset at any point:
  - next cycle: busy=0, ready=0, div_by_zero=0, hi=lo=0, state IDLE;
  - any in-flight op is discarded with no ready pulse.
- reset has priority over start and over direct writes.

## Structure
- Package muldiv_pkg holds:
  - op encoding constants MULT/MULTU/DIV/DIVU;
  - the state enum IDLE/CALC/FIX/DONE;
  - a function returning the two's-complement magnitude of a WIDTH-bit value.
- Single module; no sub-module. Datapath is an accumulator/remainder register, a multiplicand/divisor register, a quotient/multiplier shift register, and a counter of $clog2(WIDTH+1) bits.

## Test plan
- WIDTH=32, MULTU a=0xFFFFFFFF b=0xFFFFFFFF at cycle 0 -> busy cycles 1..33, ready only in cycle 34, hi=0xFFFFFFFE lo=0x00000001, div_by_zero=0.
- MULT a=−3 b=7 -> hi=0xFFFFFFFF lo=0xFFFFFFEB. Then DIV a=−7 b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF. Then DIVU a=100 b=7 -> lo=14 hi=2.
- DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0. Then DIVU a=5 b=0 -> lo=0xFFFFFFFF hi=5, div_by_zero=1 in the ready cycle and held. Next MULTU clears it.
- MULTU 6×7 started, start with different operands at cycle 5 -> ignored; result still lo=42 hi=0. hi_we at cycle 5 -> ignored. lo_we=1 lo_wdata=0x1234 while idle -> lo=0x1234 next cycle.
- DIVU 100/7 started, reset asserted in cycle 10 -> cycle 11: busy=0, hi=lo=0, no ready pulse ever. A fresh start in cycle 12 completes normally with ready in cycle 46.
- WIDTH=8: MULTU 0xFF×0x02 -> hi=0x01 lo=0xFE, ready in cycle 10. DIV a=0x80 b=0xFF -> lo=0x80 hi=0x00.
